// File: rtl/int2fp_convert.sv
// =============================================================================
// int2fp_convert
// -----------------------------------------------------------------------------
// Pipelined signed 32-bit integer to IEEE-754 single-precision converter for
// the miniGPU datapath. One operand per cycle over a valid/ready handshake,
// the rounded float appears three register stages later. Full backpressure
// with bubble collapsing: every stage advances whenever it is empty or its
// downstream stage is loading.
//
//   S1 : sign / magnitude split (|0x80000000| stays 0x80000000)
//   S2 : leading-zero count and normalisation (bit 31 = 1), biased exponent
//   S3 : round-to-nearest-even, exponent carry, result / inexact registers
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   in_valid     in   operand present
//   in_ready     out  converter can accept an operand this cycle
//   in_int[31:0] in   two's-complement operand
//   in_unsigned  in   treat in_int as unsigned (INT2FP_UNSIGNED_EN builds only)
//   out_valid    out  result present
//   out_ready    in   consumer accepts the result this cycle
//   out_float    out  {sign, exp[7:0], frac[22:0]}
//   out_inexact  out  result differs from the exact integer value
//
// Configuration
//   INT2FP_UNSIGNED_EN : when defined, adds the in_unsigned port. When it is
//                        1 the operand is taken as an unsigned magnitude.
//                        When undefined the operand is always signed.
//
// Results are never -0.0, NaN, Inf or denormal: a 32-bit integer magnitude
// always fits the single-precision exponent range.
// =============================================================================
module int2fp_convert (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_int,
`ifdef INT2FP_UNSIGNED_EN
    input  logic        in_unsigned,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_float,
    output logic        out_inexact
);

    // -------------------------------------------------------------------------
    // Leading-zero count of a 32-bit word; 32 for an all-zero word.
    // Scans upward so the highest set bit is the last one to update the count.
    // -------------------------------------------------------------------------
    function automatic logic [5:0] clz32(input logic [31:0] value);
        logic [5:0] count;
        count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (value[i]) begin
                count = 6'(31 - i);
            end else begin
                count = count;
            end
        end
        return count;
    endfunction

    // Pipeline valid bits
    logic        v1_r;
    logic        v2_r;
    logic        v3_r;

    // Stage load enables
    logic        load1_s;
    logic        load2_s;
    logic        load3_s;

    // S1 registers and their next-state values
    logic        s1_sign_r;
    logic [31:0] s1_mag_r;
    logic        s1_sign_next_s;
    logic [31:0] s1_mag_next_s;

    // S2 registers and their next-state values
    logic        s2_sign_r;
    logic        s2_zero_r;
    logic [7:0]  s2_exp_r;
    logic [30:0] s2_norm_r;      // normalised magnitude without its implicit 1
    logic [5:0]  lz_s;
    logic [31:0] norm_s;
    logic [7:0]  s2_exp_next_s;

    // S3 rounding signals and output registers
    logic [22:0] frac_trunc_s;
    logic        guard_s;
    logic        sticky_s;
    logic        round_up_s;
    logic        carry_s;
    logic [22:0] frac_rnd_s;
    logic [7:0]  exp_rnd_s;
    logic [31:0] result_s;
    logic        inexact_s;
    logic [31:0] out_float_r;
    logic        out_inexact_r;

    // Handshake: each stage loads when empty or when the stage after it loads
    always_comb begin
        load3_s = !v3_r || out_ready;
        load2_s = !v2_r || load3_s;
        load1_s = !v1_r || load2_s;
        if (reset) begin
            in_ready = 1'b0;
        end else begin
            in_ready = load1_s;
        end
    end

    // S1 next state: split the operand into sign and 32-bit magnitude
    always_comb begin
`ifdef INT2FP_UNSIGNED_EN
        s1_sign_next_s = in_int[31] & ~in_unsigned;
`else
        s1_sign_next_s = in_int[31];
`endif
        // Negating 0x80000000 wraps back to 0x80000000, the correct magnitude
        if (s1_sign_next_s) begin
            s1_mag_next_s = ~in_int + 32'd1;
        end else begin
            s1_mag_next_s = in_int;
        end
    end

    // S1 register: capture sign/magnitude on an accepted transfer
    always_ff @(posedge clock) begin
        if (reset) begin
            v1_r      <= 1'b0;
            s1_sign_r <= 1'b0;
            s1_mag_r  <= 32'd0;
        end else if (load1_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
                s1_sign_r <= s1_sign_next_s;
                s1_mag_r  <= s1_mag_next_s;
            end else begin
                s1_sign_r <= s1_sign_r;
                s1_mag_r  <= s1_mag_r;
            end
        end else begin
            v1_r      <= v1_r;
            s1_sign_r <= s1_sign_r;
            s1_mag_r  <= s1_mag_r;
        end
    end

    // S2 next state: normalise so the leading one sits at bit 31
    always_comb begin
        lz_s          = clz32(s1_mag_r);
        norm_s        = s1_mag_r << lz_s;
        // Bias 127 plus 31 for the binary point sitting left of bit 31
        s2_exp_next_s = 8'd158 - {2'b00, lz_s};
    end

    // S2 register: advance the normalised operand
    always_ff @(posedge clock) begin
        if (reset) begin
            v2_r      <= 1'b0;
            s2_sign_r <= 1'b0;
            s2_zero_r <= 1'b0;
            s2_exp_r  <= 8'd0;
            s2_norm_r <= 31'd0;
        end else if (load2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                s2_sign_r <= s1_sign_r;
                // A zero magnitude is the only case with no leading one
                s2_zero_r <= ~norm_s[31];
                s2_exp_r  <= s2_exp_next_s;
                s2_norm_r <= norm_s[30:0];
            end else begin
                s2_sign_r <= s2_sign_r;
                s2_zero_r <= s2_zero_r;
                s2_exp_r  <= s2_exp_r;
                s2_norm_r <= s2_norm_r;
            end
        end else begin
            v2_r      <= v2_r;
            s2_sign_r <= s2_sign_r;
            s2_zero_r <= s2_zero_r;
            s2_exp_r  <= s2_exp_r;
            s2_norm_r <= s2_norm_r;
        end
    end

    // S3 next state: round to nearest even and assemble the IEEE word
    always_comb begin
        frac_trunc_s          = s2_norm_r[30:8];
        guard_s               = s2_norm_r[7];
        sticky_s              = |s2_norm_r[6:0];
        round_up_s            = guard_s & (sticky_s | frac_trunc_s[0]);
        // Carry out of the fraction leaves it all-zero and bumps the exponent
        {carry_s, frac_rnd_s} = {1'b0, frac_trunc_s} + {23'd0, round_up_s};
        exp_rnd_s             = s2_exp_r + {7'd0, carry_s};
        if (s2_zero_r) begin
            result_s  = 32'd0;
            inexact_s = 1'b0;
        end else begin
            result_s  = {s2_sign_r, exp_rnd_s, frac_rnd_s};
            inexact_s = guard_s | sticky_s;
        end
    end

    // S3 register: results hold steady while the consumer stalls
    always_ff @(posedge clock) begin
        if (reset) begin
            v3_r          <= 1'b0;
            out_float_r   <= 32'd0;
            out_inexact_r <= 1'b0;
        end else if (load3_s) begin
            v3_r <= v2_r;
            if (v2_r) begin
                out_float_r   <= result_s;
                out_inexact_r <= inexact_s;
            end else begin
                out_float_r   <= out_float_r;
                out_inexact_r <= out_inexact_r;
            end
        end else begin
            v3_r          <= v3_r;
            out_float_r   <= out_float_r;
            out_inexact_r <= out_inexact_r;
        end
    end

    assign out_valid   = v3_r;
    assign out_float   = out_float_r;
    assign out_inexact = out_inexact_r;

endmodule

// File: tb/tb_int2fp_convert.sv
module tb_int2fp_convert;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_int;
    logic        in_unsigned;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_float;
    logic        out_inexact;

    int checks;
    int failures;

    int2fp_convert dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_int      (in_int),
`ifdef INT2FP_UNSIGNED_EN
        .in_unsigned (in_unsigned),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_float   (out_float),
        .out_inexact (out_inexact)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference conversion {inexact, float}: exact integer arithmetic on the
    // magnitude, rounding by comparing the discarded remainder to one half.
    function automatic logic [32:0] ref_conv(input logic [31:0] v, input logic uns);
        longint unsigned m, mant, rem, half;
        int e, sh;
        logic s, inex;
        s = v[31] & ~uns;
        m = s ? (64'd4294967296 - {32'd0, v}) : {32'd0, v};
        if (m == 64'd0) return 33'd0;
        e = 31;
        while (((m >> e) & 64'd1) == 64'd0) e--;
        inex = 1'b0;
        if (e <= 23) begin
            mant = m << (23 - e);
        end else begin
            sh   = e - 23;
            mant = m >> sh;
            rem  = m & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            inex = (rem != 64'd0);
            if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
            if (mant == (64'd1 << 24)) begin
                mant = mant >> 1;
                e    = e + 1;
            end
        end
        return {inex, s, 8'(e + 127), mant[22:0]};
    endfunction

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_int = 32'h1234_5678; out_ready = 1'b1; in_unsigned = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_float !== 32'h0000_0000) begin failures++; $display("FAIL reset_out_float got=%h exp=00000000", out_float); end
        checks++; if (out_inexact !== 1'b0) begin failures++; $display("FAIL reset_out_inexact got=%b exp=0", out_inexact); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        @(posedge clock); #1;
    endtask

    task automatic test_basic;
        logic [31:0] vec   [4] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] exp_f [4] = '{32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 32'hCF00_0000};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_int = vec[i];
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready[%0d] got=%b exp=1", i, in_ready); end
            @(posedge clock); #1;
            in_valid = 1'b0; in_int = 32'hA5A5_A5A5;
            for (int k = 0; k < 2; k++) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid[%0d] edge=%0d got=%b exp=0", i, k + 1, out_valid); end
                @(posedge clock); #1;
            end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency[%0d] got=%b exp=1", i, out_valid); end
            checks++; if (out_float !== exp_f[i]) begin failures++; $display("FAIL basic_float[%0d] in=%h got=%h exp=%h", i, vec[i], out_float, exp_f[i]); end
            checks++; if (out_inexact !== 1'b0) begin failures++; $display("FAIL basic_inexact[%0d] got=%b exp=0", i, out_inexact); end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_rounding;
        logic [31:0] vec   [3] = '{32'd16777217, 32'd16777219, 32'h7FFF_FFFF};
        logic [31:0] exp_f [3] = '{32'h4B80_0000, 32'h4B80_0002, 32'h4F00_0000};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_int = vec[i];
            @(posedge clock); #1;
            in_valid = 1'b0;
            @(posedge clock); #1;
            @(posedge clock); #1;
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL round_valid[%0d] got=%b exp=1", i, out_valid); end
            checks++; if (out_float !== exp_f[i]) begin failures++; $display("FAIL round_float[%0d] in=%h got=%h exp=%h", i, vec[i], out_float, exp_f[i]); end
            checks++; if (out_inexact !== 1'b1) begin failures++; $display("FAIL round_inexact[%0d] got=%b exp=1", i, out_inexact); end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_backpressure;
        logic [31:0] ops [10] = '{32'd1, 32'hFFFF_FFFE, 32'd16777217, 32'd0, 32'h7FFF_FFFF,
                                  32'd1000, 32'h8000_0000, 32'd16777219, 32'hFFFF_FC18, 32'd3};
        logic [32:0] expq[$];
        logic [32:0] e;
        logic held;
        logic [31:0] held_f;
        logic held_x;
        int sent, recvd, cyc;
        sent = 0; recvd = 0; cyc = 0; held = 1'b0; held_f = 32'd0; held_x = 1'b0;
        while (recvd < 10 && cyc < 400) begin
            out_ready = (cyc < 4) ? 1'b0 : 1'($urandom_range(0, 1));
            in_valid  = (sent < 10);
            in_int    = (sent < 10) ? ops[sent] : 32'hDEAD_BEEF;
            #1;
            checks++;
            if (in_ready !== !(expq.size() == 3 && !out_ready)) begin
                failures++; $display("FAIL bp_in_ready cyc=%0d occ=%0d got=%b exp=%b", cyc, expq.size(), in_ready, !(expq.size() == 3 && !out_ready));
            end
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_float !== held_f || out_inexact !== held_x) begin
                    failures++; $display("FAIL bp_stall_hold cyc=%0d got=%b/%h/%b exp=1/%h/%b", cyc, out_valid, out_float, out_inexact, held_f, held_x);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++; $display("FAIL bp_extra_result cyc=%0d got=%h exp=none", cyc, out_float);
                end else begin
                    e = expq.pop_front();
                    if ({out_inexact, out_float} !== e) begin
                        failures++; $display("FAIL bp_result[%0d] got=%b/%h exp=%b/%h", recvd, out_inexact, out_float, e[32], e[31:0]);
                    end
                end
                recvd++;
            end
            held   = out_valid && !out_ready;
            held_f = out_float;
            held_x = out_inexact;
            if (in_valid && in_ready) begin
                expq.push_back(ref_conv(ops[sent], 1'b0));
                sent++;
            end
            @(posedge clock); #1;
            cyc++;
        end
        checks++; if (recvd != 10) begin failures++; $display("FAIL bp_count got=%0d exp=10", recvd); end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] ops [100];
        logic [32:0] e;
        for (int i = 0; i < 100; i++) begin
            ops[i] = (i % 4 == 0) ? 32'($urandom_range(0, 70000)) : $urandom;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 103; c++) begin
            in_valid = (c < 100);
            in_int   = (c < 100) ? ops[c] : 32'h0BAD_F00D;
            #1;
            if (c < 100) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1", c, in_ready); end
            end
            if (c >= 3) begin
                e = ref_conv(ops[c - 3], 1'b0);
                checks++;
                if (out_valid !== 1'b1 || {out_inexact, out_float} !== e) begin
                    failures++; $display("FAIL b2b_result[%0d] in=%h got=%b/%b/%h exp=1/%b/%h", c - 3, ops[c - 3], out_valid, out_inexact, out_float, e[32], e[31:0]);
                end
            end else begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_fill_valid cyc=%0d got=%b exp=0", c, out_valid); end
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b1;
        in_valid = 1'b1; in_int = 32'd100;
        @(posedge clock); #1;
        in_int = 32'd200;
        @(posedge clock); #1;
        in_valid = 1'b0; reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_in_ready got=%b exp=0", in_ready); end
        @(posedge clock); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_float !== 32'h0000_0000) begin failures++; $display("FAIL mid_reset_float got=%h exp=00000000", out_float); end
        checks++; if (out_inexact !== 1'b0) begin failures++; $display("FAIL mid_reset_inexact got=%b exp=0", out_inexact); end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale_valid edge=%0d got=%b exp=0", k, out_valid); end
        end
        in_valid = 1'b1; in_int = 32'd5;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        checks++;
        if (out_valid !== 1'b1 || out_float !== 32'h40A0_0000 || out_inexact !== 1'b0) begin
            failures++; $display("FAIL mid_after_reset got=%b/%h/%b exp=1/40a00000/0", out_valid, out_float, out_inexact);
        end
        @(posedge clock); #1;
    endtask

`ifdef INT2FP_UNSIGNED_EN
    task automatic test_unsigned;
        logic [31:0] vec   [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        logic        uns   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp_f [4] = '{32'h4F80_0000, 32'h4F00_0000, 32'hBF80_0000, 32'hCF00_0000};
        logic        exp_x [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_int = vec[i]; in_unsigned = uns[i];
            @(posedge clock); #1;
            in_valid = 1'b0; in_unsigned = ~uns[i];
            @(posedge clock); #1;
            @(posedge clock); #1;
            checks++;
            if (out_valid !== 1'b1 || out_float !== exp_f[i] || out_inexact !== exp_x[i]) begin
                failures++; $display("FAIL unsigned[%0d] got=%b/%h/%b exp=1/%h/%b", i, out_valid, out_float, out_inexact, exp_f[i], exp_x[i]);
            end
        end
        in_unsigned = 1'b0;
        @(posedge clock); #1;
    endtask
`endif

    initial begin
        checks = 0; failures = 0;
        test_reset();
        test_basic();
        test_rounding();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
`ifdef INT2FP_UNSIGNED_EN
        test_unsigned();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
